// File: rtl/lsb_three_approximate_rc_adder_pkg.sv
// Shared definitions for the approximate ripple-carry adder.
// Holds the default operand width, the default number of approximate LSBs,
// the operand and result types, and a helper that returns the worst-case
// absolute error for a given number of approximate bits.
package lsb_three_approximate_rc_adder_pkg;

  localparam int ADDER_WIDTH       = 8;
  localparam int ADDER_APPROX_BITS = 3;

  // One operand.
  typedef logic [ADDER_WIDTH-1:0] operand_t;
  // Complete result {Cout, S}.
  typedef logic [ADDER_WIDTH:0]   result_t;

  // The lower part never produces a result further than this from the
  // exact sum.
  function automatic int approx_error_bound(input int approx_bits);
    return (1 << approx_bits) - 1;
  endfunction

endpackage

// File: rtl/lsb_three_approximate_rc_adder_full_adder_cell.sv
// Single-bit exact full adder used for the upper part of the ripple chain.
// Ports:
//   a_i, b_i  operand bits
//   ci_i      carry in
//   s_o       sum bit
//   co_o      carry out
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  // Propagate term is shared between the sum and the carry.
  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

// File: rtl/lsb_three_approximate_rc_adder.sv
// Registered approximate adder. The lowest APPROX_BITS bits are formed with
// a lower-part OR (no carry between them); the upper bits form an exact
// ripple-carry chain of full_adder_cell instances. The result {Cout, S}
// appears one cycle after an accepted input.
//
// Handshake: an input is accepted on every rising clk edge where in_valid
// is 1 (no backpressure). out_valid is 1 for exactly the cycle after each
// accepted input; when out_valid is 0, S and Cout keep their last value.
// rst clears S, Cout and out_valid immediately and overrides in_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   A/B/Cin are valid this cycle
//   A, B       unsigned operands (WIDTH bits)
//   Cin        carry in
//   S          registered approximate sum (WIDTH bits)
//   Cout       registered carry out
//   out_valid  S/Cout hold the result of an accepted input
//
// APPROX_BITS may be 0 (exact adder) up to WIDTH (fully approximate).
module lsb_three_approximate_rc_adder
  import lsb_three_approximate_rc_adder_pkg::*;
#(
  parameter int WIDTH       = ADDER_WIDTH,
  parameter int APPROX_BITS = ADDER_APPROX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH-1:0]           sum_c;
  // carry_c[i] is the carry into bit i; only the exact region has carries.
  logic [WIDTH:APPROX_BITS]   carry_c;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  generate
    if (APPROX_BITS == 0) begin : g_no_approx
      assign carry_c[0] = Cin;
    end else begin : g_approx
      // Cin has nowhere to ripple, so it is folded into the OR of bit 0.
      assign sum_c[0] = A[0] | B[0] | Cin;
      for (genvar i = 1; i < APPROX_BITS; i++) begin : g_or
        assign sum_c[i] = A[i] | B[i];
      end
      // Only the top approximate bit can generate a carry into the exact part.
      assign carry_c[APPROX_BITS] = A[APPROX_BITS-1] & B[APPROX_BITS-1];
    end

    for (genvar i = APPROX_BITS; i < WIDTH; i++) begin : g_exact
      full_adder_cell u_fa (
        .a_i  (A[i]),
        .b_i  (B[i]),
        .ci_i (carry_c[i]),
        .s_o  (sum_c[i]),
        .co_o (carry_c[i+1])
      );
    end
  endgenerate

  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      s_d     = sum_c;
      cout_d  = carry_c[WIDTH];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_lsb_three_approximate_rc_adder.sv
module tb_lsb_three_approximate_rc_adder;
  import lsb_three_approximate_rc_adder_pkg::*;

  localparam int W = ADDER_WIDTH;
  localparam int K = ADDER_APPROX_BITS;

  // ---------------- clock / reset / DUT ----------------
  logic           clk;
  logic           rst;
  logic           in_valid;
  operand_t       A;
  operand_t       B;
  logic           Cin;
  operand_t       S;
  logic           Cout;
  logic           out_valid;

  lsb_three_approximate_rc_adder #(.WIDTH(W), .APPROX_BITS(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .S         (S),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  result_t exp_q[$];
  int      exact_q[$];
  int      passed;
  int      total;
  logic    stim_done;

  // Reference model: the low field is the bitwise OR of the operands' low
  // fields (plus Cin), the high field is the arithmetic sum of the operands'
  // high fields plus the carry generated by the top approximate bit.
  function automatic result_t model(input operand_t a, input operand_t b, input logic cin);
    int mask, low, hi, g;
    if (K == 0) return result_t'(int'(a) + int'(b) + int'(cin));
    mask = (1 << K) - 1;
    low  = (int'(a) & mask) | (int'(b) & mask) | int'(cin);
    g    = ((int'(a) >> (K - 1)) & (int'(b) >> (K - 1))) & 1;
    hi   = (int'(a) >> K) + (int'(b) >> K) + g;
    return result_t'((hi << K) | low);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input operand_t a, input operand_t b, input logic cin, input result_t e);
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = 1'b1;
    exp_q.push_back(e);
    exact_q.push_back(int'(a) + int'(b) + int'(cin));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = operand_t'($urandom);
    B        = operand_t'($urandom);
    Cin      = 1'($urandom);
  endtask

  // ---------------- monitor / checker ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin : monitor
    result_t got;
    result_t want;
    result_t exp_hold;
    int      ex;
    int      diff;
    logic    prev_iv;
    passed   = 0;
    total    = 0;
    prev_iv  = 1'b0;
    exp_hold = '0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        check("rst_S", int'(S), 0);
        check("rst_Cout", int'(Cout), 0);
        check("rst_out_valid", int'(out_valid), 0);
        exp_q.delete();
        exact_q.delete();
        prev_iv  = 1'b0;
        exp_hold = '0;
      end else begin
        check("out_valid_delay", int'(out_valid), int'(prev_iv));
        got = {Cout, S};
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_result: got 0x%0h with no expected entry (t=%0t)", got, $time);
          end else begin
            want = exp_q.pop_front();
            ex   = exact_q.pop_front();
            check("sum", int'(got), int'(want));
            diff = int'(got) - ex;
            if (diff < 0) diff = -diff;
            total++;
            if (diff <= approx_error_bound(K)) passed++;
            else $display("FAIL err_bound: got 0x%0h exact 0x%0h |err| %0d allowed %0d",
                          got, ex, diff, approx_error_bound(K));
            exp_hold = want;
          end
        end else begin
          check("hold", int'(got), int'(exp_hold));
        end
        prev_iv = in_valid;
        if (stim_done) begin
          check("queue_empty", exp_q.size(), 0);
          $display("%0d/%0d checks passed", passed, total);
          $finish;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    stim_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases with hand-computed results.
    issue(8'h08, 8'h10, 1'b0, 9'h018);
    issue(8'h05, 8'h03, 1'b0, 9'h007);
    issue(8'h04, 8'h04, 1'b0, 9'h00C);
    issue(8'hFF, 8'hFF, 1'b0, 9'h1FF);
    issue(8'hFF, 8'h01, 1'b0, 9'h0FF);
    issue(8'h00, 8'h00, 1'b1, 9'h001);
    issue(8'h04, 8'h04, 1'b1, 9'h00D);

    // Drop in_valid: outputs hold, out_valid falls.
    repeat (3) idle();

    // Reset mid-stream while in_valid stays high: in-flight result dropped.
    issue(8'h21, 8'h42, 1'b0, model(8'h21, 8'h42, 1'b0));
    issue(8'h7E, 8'h81, 1'b1, model(8'h7E, 8'h81, 1'b1));
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    // First valid input after reset is captured on the next edge.
    issue(8'h33, 8'h44, 1'b0, model(8'h33, 8'h44, 1'b0));
    idle();

    // Exhaustive sweep with Cin = 0, back to back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        issue(operand_t'(a), operand_t'(b), 1'b0, model(operand_t'(a), operand_t'(b), 1'b0));
      end
    end
    idle();

    // Random sample with Cin = 1 and random gaps in in_valid.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        operand_t ra, rb;
        ra = operand_t'($urandom_range(0, 255));
        rb = operand_t'($urandom_range(0, 255));
        issue(ra, rb, 1'b1, model(ra, rb, 1'b1));
      end
    end

    repeat (2) idle();
    @(posedge clk);
    #1 stim_done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL watchdog: monitor did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lsb_three_approximate_rc_adder.md
Name: lsb_three_approximate_rc_adder

Overview:
- Registered 8-bit adder built as a ripple chain; the upper 5 bits are exact, the lowest 3 bits use a lower-part-OR approximation.
- Trades accuracy in the 3 LSBs for a shorter carry chain and less area.
- Sits in the filter datapath wherever an approximate sum of two unsigned 8-bit operands is acceptable.
- Result {Cout,S} is a 9-bit value with one cycle of latency.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- APPROX_BITS, 3, number of LSBs computed approximately; legal range 0..WIDTH. 0 gives an exact adder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- Cin  input  1  carry-in.
- S  output  WIDTH  registered approximate sum.
- Cout  output  1  registered carry-out.
- out_valid  output  1  S/Cout hold the result of an accepted input.

Behaviour:
- Combinational core, lower part (bits i < APPROX_BITS):
  - s[i] = A[i] | B[i]; bit 0 additionally ORs in Cin: s[0] = A[0] | B[0] | Cin.
  - No carry ripples between approximate bits.
- Carry into bit APPROX_BITS = A[APPROX_BITS-1] & B[APPROX_BITS-1]. When APPROX_BITS = 0 it is Cin.
- Upper part (bits APPROX_BITS..WIDTH-1): exact ripple-carry full adders.
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i])
- cout = carry out of bit WIDTH-1. No overflow flag; the 9-bit {Cout,S} is the complete result.
- Registering:
  - On a rising clk edge with in_valid=1: S <= s, Cout <= cout, out_valid <= 1.
  - On an edge with in_valid=0: S and Cout hold, out_valid <= 0.
- Latency is exactly 1 cycle. Throughput is one result per cycle with back-to-back in_valid. No backpressure.
- Reset: rst=1 forces S=0, Cout=0, out_valid=0 immediately, without waiting for clk. Held while rst=1.
  - Reset overrides a simultaneous in_valid.
  - The first valid input after rst deasserts is captured on the next edge.
  - Reset mid-stream drops any in-flight result.
- Error bound: the approximate result is never more than 2^APPROX_BITS - 1 away from the exact sum. With the default, |error| <= 7.

Decomposition:
- Shared package holds:
  - constants ADDER_WIDTH=8 and ADDER_APPROX_BITS=3;
  - typedef operand_t (logic [WIDTH-1:0]);
  - typedef result_t (logic [WIDTH:0]) for {Cout,S}.
- One natural sub-module: full_adder_cell (a, b, ci -> s, co).
  - Instantiated by a generate loop for the exact upper bits.
  - Approximate bits are plain OR/AND logic in the top level.

Test Plan:
- Exact-region add: A=0x08, B=0x10, Cin=0 -> one cycle later {Cout,S}=0x018 (exact), out_valid=1.
- Lower OR, no carry: A=0x05, B=0x03, Cin=0 -> S=0x07, Cout=0 (exact 0x008, error -1).
- Generated carry from bit 2: A=0x04, B=0x04 -> S=0x0C, Cout=0 (exact 0x008, error +4). A=0xFF, B=0xFF -> {Cout,S}=0x1FF (exact 0x1FE).
- Missed carry: A=0xFF, B=0x01 -> S=0xFF, Cout=0 (exact 0x100, error -1).
- Exhaustive sweep:
  - All 65536 A/B pairs with Cin=0, plus a random sample with Cin=1, compared against a reference model of the rules above.
  - Check |approx - exact| <= 7 on every pair.
  - Check out_valid follows in_valid delayed by one cycle.
- Reset and hold:
  - Assert rst asynchronously mid-stream -> S=0, Cout=0, out_valid=0 before the next edge.
  - Drop in_valid -> outputs hold their last value and out_valid=0.
